// File: rtl/qarma_round_sequencer.sv
// Purpose : sequences an iterative QARMA-64 round datapath (load, fwd, reflector, bwd, whitening).
// Latency : start sampled in cycle 0 -> done_o pulse in cycle 2*ROUNDS+4 (cycle 18 for ROUNDS=7).
// Backpressure: none; start_i while busy is dropped, abort_i returns to IDLE at the next edge.
//
// Ports:
//   wb_clk_i, wb_rst_n        clock, synchronous active-low reset
//   start_i, decrypt_i        request + direction (sampled only in IDLE)
//   abort_i, irq_clr_i        cancel operation, clear sticky irq
//   busy_o, done_o, irq_o     status: busy, one-cycle done pulse, sticky completion flag
//   dp_*                      registered datapath controls (load, round enable, phase, index,
//                             short round, direction, final whitening)
// Optional: define QARMA_OP_COUNT_EN to add op_count_o[15:0], a wrapping count of completions.

module qarma_round_sequencer #(
    parameter int ROUNDS = 7,
    parameter int CNT_W  = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             start_i,
    input  logic             decrypt_i,
    input  logic             abort_i,
    input  logic             irq_clr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             irq_o,
    output logic             dp_load_o,
    output logic             dp_round_en_o,
    output logic [1:0]       dp_phase_o,
    output logic [CNT_W-1:0] dp_round_idx_o,
    output logic             dp_short_o,
    output logic             dp_decrypt_o,
    output logic             dp_final_o
`ifdef QARMA_OP_COUNT_EN
    ,
    output logic [15:0]      op_count_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FWD,
        S_REFL,
        S_BWD,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dec_nxt;

    // Output values for the cycle following this edge; they are derived from the
    // next state/counter so every dp_* output comes straight from a flop.
    logic             busy_nxt, done_nxt, irq_nxt, load_nxt, round_en_nxt, short_nxt, final_nxt;
    logic [1:0]       phase_nxt;
    logic [CNT_W-1:0] idx_nxt;

    // ---------------------------------------------------------------------
    // Next-state / counter logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dec_nxt   = dp_decrypt_o;

        case (state)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_nxt = S_LOAD;
                    dec_nxt   = decrypt_i;
                    cnt_nxt   = '0;
                end
            end
            S_LOAD: begin
                state_nxt = S_FWD;
                cnt_nxt   = '0;
            end
            S_FWD: begin
                // Leave at the terminal index so the counter never wraps.
                if (cnt == LAST_IDX) begin
                    state_nxt = S_REFL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_REFL: begin
                state_nxt = S_BWD;
                cnt_nxt   = LAST_IDX;
            end
            S_BWD: begin
                if (cnt == '0) begin
                    state_nxt = S_FINAL;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_FINAL: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Abort overrides everything outside IDLE; in DONE the pulse already happened.
        if (abort_i && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Next output values
    // ---------------------------------------------------------------------
    always_comb begin
        busy_nxt     = (state_nxt != S_IDLE);
        done_nxt     = (state_nxt == S_DONE);
        load_nxt     = (state_nxt == S_LOAD);
        final_nxt    = (state_nxt == S_FINAL);
        round_en_nxt = 1'b0;
        phase_nxt    = 2'd0;
        idx_nxt      = '0;
        short_nxt    = 1'b0;

        case (state_nxt)
            S_FWD: begin
                round_en_nxt = 1'b1;
                phase_nxt    = 2'd0;
                idx_nxt      = cnt_nxt;
                short_nxt    = (cnt_nxt == '0);
            end
            S_REFL: begin
                round_en_nxt = 1'b1;
                phase_nxt    = 2'd1;
            end
            S_BWD: begin
                round_en_nxt = 1'b1;
                phase_nxt    = 2'd2;
                idx_nxt      = cnt_nxt;
                short_nxt    = (cnt_nxt == '0);
            end
            default: ;
        endcase

        // irq rises together with done_o. A clear seen while entering or sitting
        // in DONE loses against the completion that sets the flag.
        irq_nxt = (state_nxt == S_DONE) || (state == S_DONE) || (irq_o && !irq_clr_i);
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            irq_o          <= 1'b0;
            dp_load_o      <= 1'b0;
            dp_round_en_o  <= 1'b0;
            dp_phase_o     <= 2'd0;
            dp_round_idx_o <= '0;
            dp_short_o     <= 1'b0;
            dp_decrypt_o   <= 1'b0;
            dp_final_o     <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            busy_o         <= busy_nxt;
            done_o         <= done_nxt;
            irq_o          <= irq_nxt;
            dp_load_o      <= load_nxt;
            dp_round_en_o  <= round_en_nxt;
            dp_phase_o     <= phase_nxt;
            dp_round_idx_o <= idx_nxt;
            dp_short_o     <= short_nxt;
            dp_decrypt_o   <= dec_nxt;
            dp_final_o     <= final_nxt;
        end
    end

`ifdef QARMA_OP_COUNT_EN
    // Counts in the DONE cycle itself, so an abort landing in DONE still counts.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            op_count_o <= 16'h0000;
        end else if (state == S_DONE) begin
            op_count_o <= op_count_o + 16'h0001;
        end
    end
`endif

endmodule
